cordic_arbiter: RTL and testbench

- Shares one pipelined CORDIC rotator among NUM_REQ requesters.
- Round-robin arbitration with valid/ready handshakes. Launches at most one rotation per cycle into the CORDIC.
- Tracks an ID/valid shadow pipeline matched to the CORDIC latency and returns each result tagged with its requester ID.
- Provides a flush/drain sequence so software or a sequencer can quiesce the datapath, e.g. before changing mode or gating the clock.

---
 rtl/cordic_pkg.sv | 25 ++
 rtl/cordic_tag_pipe.sv | 26 ++
 rtl/cordic_arbiter.sv | 168 ++++++++++++++++
 tb/tb_cordic_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types for the CORDIC request arbiter: request payload, shadow tag and arbiter state.
package cordic_pkg;

  localparam int unsigned ANGLE_W    = 32;
  localparam int unsigned DATA_MAX_W = 32;
  localparam int unsigned ID_MAX_W   = 3;
  localparam int unsigned CNT_W      = 4;

  typedef struct packed {
    logic [DATA_MAX_W-1:0] x;
    logic [DATA_MAX_W-1:0] y;
    logic [ANGLE_W-1:0]    angle;
  } rot_req_t;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cordic_tag_pipe.sv
// Delay line of {valid,id} tags that shadows the CORDIC pipeline stage for stage.
module cordic_tag_pipe
  import cordic_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one pipelined CORDIC among NUM_REQ requesters,
// with per-requester outstanding limits, tagged responses and a flush/drain sequence.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned BIT_WIDTH      = 8,
  parameter int unsigned CORDIC_LATENCY = 8,
  parameter int unsigned MAX_OUT        = 3,
  parameter int unsigned ID_W           = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_x,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_y,
  input  logic [NUM_REQ*ANGLE_W-1:0]     req_angle,
  output logic [BIT_WIDTH-1:0]           cor_xin,
  output logic [BIT_WIDTH-1:0]           cor_yin,
  output logic [ANGLE_W-1:0]             cor_angle,
  input  logic [BIT_WIDTH:0]             cor_xout,
  input  logic [BIT_WIDTH:0]             cor_yout,
  output logic                           rsp_valid,
  output logic [ID_W-1:0]                rsp_id,
  output logic [BIT_WIDTH:0]             rsp_x,
  output logic [BIT_WIDTH:0]             rsp_y,
  input  logic                           flush_req,
  output logic                           flush_done,
  output logic                           busy
);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q [NUM_REQ];
  logic [CNT_W-1:0]    cnt_d [NUM_REQ];
  rot_req_t            cor_q, cor_d;
  tag_t                tag0_q, tag0_d, tail_c;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [BIT_WIDTH:0]  rsp_x_q, rsp_y_q;
  logic                flush_done_q, flush_done_d;
  logic                busy_q;

  logic [NUM_REQ-1:0]  elig_c, inc_c, dec_c;
  logic [ID_W-1:0]     grant_c, idx_c;
  logic                grant_vld_c, accept_c;
  logic                any_cnt_q_c, any_cnt_d_c;

  // Eligibility; a flush sampled this cycle already blocks the grant.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig_c[i] = req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT)) &&
                  (state_q == RUN) && !flush_req;
    end
  end

  // First eligible requester at or after the round-robin pointer.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_c     = '0;
    idx_c       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_c = ID_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!grant_vld_c && elig_c[idx_c]) begin
        grant_vld_c = 1'b1;
        grant_c     = idx_c;
      end
    end
  end

  assign req_ready = grant_vld_c ? (NUM_REQ'(1) << grant_c) : '0;
  assign accept_c  = grant_vld_c && req_valid[grant_c];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      inc_c[i] = accept_c && (grant_c == ID_W'(i));
      dec_c[i] = rsp_valid_q && (rsp_id_q == ID_W'(i));
    end
  end

  always_comb begin
    ptr_d        = ptr_q;
    cor_d        = '0;
    tag0_d       = '0;
    state_d      = state_q;
    flush_done_d = 1'b0;
    any_cnt_q_c  = 1'b0;
    any_cnt_d_c  = 1'b0;

    if (accept_c) begin
      ptr_d        = (grant_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_c + ID_W'(1);
      cor_d.x      = DATA_MAX_W'($signed(req_x[grant_c*BIT_WIDTH +: BIT_WIDTH]));
      cor_d.y      = DATA_MAX_W'($signed(req_y[grant_c*BIT_WIDTH +: BIT_WIDTH]));
      cor_d.angle  = req_angle[grant_c*ANGLE_W +: ANGLE_W];
      tag0_d.valid = 1'b1;
      tag0_d.id    = ID_MAX_W'(grant_c);
    end

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_c[i] && !dec_c[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_c[i] && !inc_c[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      if (cnt_q[i] != '0) any_cnt_q_c = 1'b1;
      if (cnt_d[i] != '0) any_cnt_d_c = 1'b1;
    end

    case (state_q)
      RUN:     if (flush_req)    state_d = DRAIN;
      DRAIN:   if (!any_cnt_q_c) state_d = RUN;
      default: state_d = RUN;
    endcase

    // Registered one cycle early so the pulse coincides with the empty DRAIN cycle.
    flush_done_d = (state_d == DRAIN) && !any_cnt_d_c;
  end

  cordic_tag_pipe #(
    .DEPTH (CORDIC_LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag0_q),
    .tag_o (tail_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      ptr_q        <= '0;
      cor_q        <= '0;
      tag0_q       <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_x_q      <= '0;
      rsp_y_q      <= '0;
      flush_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cor_q        <= cor_d;
      tag0_q       <= tag0_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
      rsp_valid_q  <= tail_c.valid;
      rsp_id_q     <= tail_c.valid ? ID_W'(tail_c.id) : '0;
      rsp_x_q      <= tail_c.valid ? cor_xout : '0;
      rsp_y_q      <= tail_c.valid ? cor_yout : '0;
      flush_done_q <= flush_done_d;
      busy_q       <= any_cnt_d_c;
    end
  end

  assign cor_xin    = BIT_WIDTH'(cor_q.x);
  assign cor_yin    = BIT_WIDTH'(cor_q.y);
  assign cor_angle  = cor_q.angle;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_x      = rsp_x_q;
  assign rsp_y      = rsp_y_q;
  assign flush_done = flush_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter with a simple fixed-latency stand-in for the CORDIC.
module tb_cordic_arbiter;

  localparam int NR  = 4;
  localparam int BW  = 8;
  localparam int LAT = 8;
  localparam int MO  = 3;
  localparam int IDW = 2;
  localparam int OW  = BW + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*BW-1:0]  req_x, req_y;
  logic [NR*32-1:0]  req_angle;
  logic [BW-1:0]     cor_xin, cor_yin;
  logic [31:0]       cor_angle;
  logic [OW-1:0]     cor_xout, cor_yout;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [OW-1:0]     rsp_x, rsp_y;
  logic              flush_req, flush_done, busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_arbiter #(
    .NUM_REQ(NR), .BIT_WIDTH(BW), .CORDIC_LATENCY(LAT), .MAX_OUT(MO), .ID_W(IDW)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_angle(req_angle),
    .cor_xin(cor_xin), .cor_yin(cor_yin), .cor_angle(cor_angle),
    .cor_xout(cor_xout), .cor_yout(cor_yout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .flush_req(flush_req), .flush_done(flush_done), .busy(busy)
  );

  function automatic int model_x(input int x, input int y);
    return x + y;
  endfunction

  function automatic int model_y(input int x, input int y, input logic [31:0] a);
    return y - x + int'(a[31:29]);
  endfunction

  // Stand-in rotator: samples cor_* each edge, result appears LAT cycles later.
  logic [OW-1:0] mx [LAT];
  logic [OW-1:0] my [LAT];
  always @(posedge clk) begin
    mx[0] <= OW'(model_x(int'($signed(cor_xin)), int'($signed(cor_yin))));
    my[0] <= OW'(model_y(int'($signed(cor_xin)), int'($signed(cor_yin)), cor_angle));
    for (int k = 1; k < LAT; k++) begin
      mx[k] <= mx[k-1];
      my[k] <= my[k-1];
    end
  end
  assign cor_xout = mx[LAT-1];
  assign cor_yout = my[LAT-1];

  typedef struct {
    int id;
    int x;
    int y;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input int x, input int y);
    sb.push_back('{id, x, y, cyc + LAT + 2});
  endtask

  task automatic set_req(input int i, input int x, input int y, input logic [31:0] a);
    req_x[i*BW +: BW]     = BW'(x);
    req_y[i*BW +: BW]     = BW'(y);
    req_angle[i*32 +: 32] = a;
  endtask

  // Monitor: every response must match the oldest expected entry, including its cycle.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id %0d at cycle %0d, expected no response", rsp_id, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id",    int'(rsp_id),         mon_e.id);
        check("rsp_x",     int'($signed(rsp_x)), mon_e.x);
        check("rsp_y",     int'($signed(rsp_y)), mon_e.y);
        check("rsp_cycle", cyc,                  mon_e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_angle = '0; flush_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready",  int'(req_ready), 0);
    check("rst_xin",    int'(cor_xin), 0);
    check("rst_angle",  int'(cor_angle), 0);
    check("rst_rsp",    int'(rsp_valid), 0);
    check("rst_done",   int'(flush_done), 0);
    check("rst_busy",   int'(busy), 0);
    rst = 1'b0;

    // Single request from requester 2, hand-computed result.
    @(negedge clk);
    set_req(2, 100, 0, 32'h2000_0000);
    req_valid = 4'b0100;
    #1;
    check("t1_ready", int'(req_ready), 4);
    sb.push_back('{2, 100, -99, cyc + LAT + 2});
    @(negedge clk);
    req_valid = '0;
    #1;
    check("t1_xin",   int'($signed(cor_xin)), 100);
    check("t1_yin",   int'($signed(cor_yin)), 0);
    check("t1_angle", int'(cor_angle), 32'h2000_0000);
    check("t1_busy",  int'(busy), 1);
    @(negedge clk);
    #1;
    check("t1_idle_xin", int'(cor_xin), 0);
    repeat (LAT + 2) @(negedge clk);
    #1;
    check("t1_busy_end", int'(busy), 0);

    // Reset pointer, then all four requesters contend with one request each.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 10 * i + 5, -3 * i, 32'(i) << 29);
    begin
      logic [NR-1:0] vmask;
      vmask = '1;
      for (int k = 0; k < NR; k++) begin
        @(negedge clk);
        req_valid = vmask;
        #1;
        check("t2_grant", int'(req_ready), 1 << k);
        push(k, model_x(10 * k + 5, -3 * k), model_y(10 * k + 5, -3 * k, 32'(k) << 29));
        vmask[k] = 1'b0;
      end
    end
    @(negedge clk);
    req_valid = '0;
    repeat (LAT + 3) @(negedge clk);

    // Requester 1 streams alone: outstanding limit, then reassert after first response.
    for (int r = 0; r < 14; r++) begin
      int er;
      @(negedge clk);
      set_req(1, 5 * r - 30, r, 32'h4000_0000);
      req_valid = 4'b0010;
      #1;
      er = (r < 3 || r >= 11) ? 2 : 0;
      check("t3_ready", int'(req_ready), er);
      if (er != 0) push(1, model_x(5 * r - 30, r), model_y(5 * r - 30, r, 32'h4000_0000));
    end
    @(negedge clk);
    req_valid = '0;
    repeat (LAT + 4) @(negedge clk);

    // Flush with an empty pipeline completes one cycle later.
    @(negedge clk);
    flush_req = 1'b1;
    #1;
    check("t4e_done0", int'(flush_done), 0);
    @(negedge clk);
    flush_req = 1'b0;
    #1;
    check("t4e_done1", int'(flush_done), 1);
    @(negedge clk);
    #1;
    check("t4e_done2", int'(flush_done), 0);

    // Flush mid-stream from requester 0.
    for (int r = 0; r < 14; r++) begin
      int er;
      @(negedge clk);
      set_req(0, r, 1, 32'h0);
      req_valid = 4'b0001;
      flush_req = (r == 2);
      #1;
      er = (r < 2 || r == 13) ? 1 : 0;
      check("t4_ready", int'(req_ready), er);
      check("t4_done",  int'(flush_done), (r == 12) ? 1 : 0);
      if (er != 0) push(0, model_x(r, 1), model_y(r, 1, 32'h0));
    end
    @(negedge clk);
    req_valid = '0;
    flush_req = 1'b0;
    repeat (LAT + 4) @(negedge clk);

    // Five rotations in flight, then reset discards them.
    for (int r = 0; r < 5; r++) begin
      @(negedge clk);
      set_req(0, r, 2, 32'h0);
      set_req(1, -r, 3, 32'h0);
      req_valid = 4'b0011;
      #1;
      check("t5_grant", int'(req_ready), (r % 2 == 0) ? 2 : 1);
    end
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("t5_busy", int'(busy), 0);
    check("t5_rsp",  int'(rsp_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    set_req(1, 9, -4, 32'hE000_0000);
    req_valid = 4'b0010;
    #1;
    check("t5_ready", int'(req_ready), 2);
    push(1, model_x(9, -4), model_y(9, -4, 32'hE000_0000));
    @(negedge clk);
    req_valid = '0;
    repeat (LAT + 6) @(negedge clk);
    #1;
    check("t5_busy_end", int'(busy), 0);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
